// File: rtl/program_loader.sv
// program_loader: framed byte-stream writer for the 4096x8 program store.
// A frame is a 12-bit length header (2 bytes), that many data bytes and,
// when LOADER_CHECKSUM_EN is defined, a trailing mod-256 checksum byte.
// Data bytes are written to consecutive addresses starting at BASE_ADDR.
// The uP is held in reset for the whole load and stays held after a failure.
// Optional feature macro: LOADER_CHECKSUM_EN (undefined = no checksum byte).
module program_loader #(
    parameter int                ADDR_W      = 12,
    parameter int                DATA_W      = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                TIMEOUT_CYC = 1023
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_byte,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code
);

    localparam int LEN_W = 12;
    localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [TMO_W:0] TMO_LIMIT = (TMO_W + 1)'(TIMEOUT_CYC);

    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
`ifdef LOADER_CHECKSUM_EN
    localparam logic [1:0] ERR_CSUM    = 2'b10;
`endif
    localparam logic [1:0] ERR_HEADER  = 2'b11;

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM, S_DONE, S_ERROR
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_DONE, S_ERROR
    } state_t;
`endif

    state_t            state_reg;
    logic [LEN_W-1:0]  len_reg;
    logic [LEN_W-1:0]  idx_reg;
    logic [TMO_W-1:0]  tmo_cnt_reg;
`ifdef LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] sum_reg;
`endif

    logic xfer;
    logic tmo_hit;
    logic last_data;
    logic len_zero;

    // The loader is ready in every state that expects a stream byte
    always_comb begin
        in_ready = 1'b0;
        case (state_reg)
            S_LEN_HI, S_LEN_LO, S_DATA: in_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            S_CSUM:                     in_ready = 1'b1;
`endif
            default:                    in_ready = 1'b0;
        endcase
    end

    assign xfer      = in_valid & in_ready;
    // Fires on the idle cycle that would bring the counter up to the limit
    assign tmo_hit   = (TIMEOUT_CYC != 0) &&
                       (({1'b0, tmo_cnt_reg} + {{TMO_W{1'b0}}, 1'b1}) == TMO_LIMIT);
    assign last_data = (idx_reg == (len_reg - LEN_W'(1)));
    assign len_zero  = ({len_reg[11:8], in_byte[7:0]} == '0);

    // Idle-gap counter: restarts on every accepted byte and on a frame start
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt_reg <= '0;
        end else if (xfer || (start && !in_ready)) begin
            tmo_cnt_reg <= '0;
        end else if (in_ready && (TIMEOUT_CYC != 0)) begin
            tmo_cnt_reg <= tmo_cnt_reg + TMO_W'(1);
        end
    end

    // Frame FSM with registered status outputs and the one-cycle-late write port
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= S_IDLE;
            len_reg   <= '0;
            idx_reg   <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum_reg   <= '0;
`endif
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            cpu_hold  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            err_code  <= 2'b00;
        end else begin
            wr_en <= 1'b0;
            if (in_ready && !xfer && tmo_hit) begin
                // A transfer in the same cycle takes priority over the timeout
                state_reg <= S_ERROR;
                error     <= 1'b1;
                err_code  <= ERR_TIMEOUT;
                cpu_hold  <= 1'b1;
                busy      <= 1'b0;
            end else begin
                case (state_reg)
                    S_IDLE, S_DONE, S_ERROR: begin
                        if (start) begin
                            state_reg <= S_LEN_HI;
                            idx_reg   <= '0;
`ifdef LOADER_CHECKSUM_EN
                            sum_reg   <= '0;
`endif
                            done      <= 1'b0;
                            error     <= 1'b0;
                            err_code  <= 2'b00;
                            cpu_hold  <= 1'b1;
                            busy      <= 1'b1;
                        end
                    end
                    S_LEN_HI: begin
                        if (xfer) begin
                            if (in_byte[7:4] != 4'h0) begin
                                state_reg <= S_ERROR;
                                error     <= 1'b1;
                                err_code  <= ERR_HEADER;
                                cpu_hold  <= 1'b1;
                                busy      <= 1'b0;
                            end else begin
                                len_reg   <= {in_byte[3:0], 8'h00};
                                state_reg <= S_LEN_LO;
                            end
                        end
                    end
                    S_LEN_LO: begin
                        if (xfer) begin
                            len_reg[7:0] <= in_byte[7:0];
                            if (len_zero) begin
`ifdef LOADER_CHECKSUM_EN
                                state_reg <= S_CSUM;
`else
                                state_reg <= S_DONE;
                                done      <= 1'b1;
                                cpu_hold  <= 1'b0;
                                busy      <= 1'b0;
`endif
                            end else begin
                                state_reg <= S_DATA;
                            end
                        end
                    end
                    S_DATA: begin
                        if (xfer) begin
                            wr_en   <= 1'b1;
                            wr_addr <= BASE_ADDR + ADDR_W'(idx_reg);
                            wr_data <= in_byte;
                            idx_reg <= idx_reg + LEN_W'(1);
`ifdef LOADER_CHECKSUM_EN
                            sum_reg <= sum_reg + in_byte;
`endif
                            if (last_data) begin
`ifdef LOADER_CHECKSUM_EN
                                state_reg <= S_CSUM;
`else
                                state_reg <= S_DONE;
                                done      <= 1'b1;
                                cpu_hold  <= 1'b0;
                                busy      <= 1'b0;
`endif
                            end
                        end
                    end
`ifdef LOADER_CHECKSUM_EN
                    S_CSUM: begin
                        if (xfer) begin
                            busy <= 1'b0;
                            if (in_byte == sum_reg) begin
                                state_reg <= S_DONE;
                                done      <= 1'b1;
                                cpu_hold  <= 1'b0;
                            end else begin
                                state_reg <= S_ERROR;
                                error     <= 1'b1;
                                err_code  <= ERR_CSUM;
                                cpu_hold  <= 1'b1;
                            end
                        end
                    end
`endif
                    default: state_reg <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed and random frames driven into two loaders that
// differ only in BASE_ADDR; writes and status are compared against a
// frame-level reference model. Works with LOADER_CHECKSUM_EN on or off.
module tb_program_loader;

    localparam logic [11:0] BASE_A = 12'h000;
    localparam logic [11:0] BASE_B = 12'hFFE;
    localparam int          TMO    = 8;
`ifdef LOADER_CHECKSUM_EN
    localparam int CSUM_BYTES = 1;
`else
    localparam int CSUM_BYTES = 0;
`endif

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_byte = 8'h00;

    logic        in_ready_a, wr_en_a, cpu_hold_a, busy_a, done_a, error_a;
    logic [11:0] wr_addr_a;
    logic [7:0]  wr_data_a;
    logic [1:0]  err_code_a;
    logic        in_ready_b, wr_en_b, cpu_hold_b, busy_b, done_b, error_b;
    logic [11:0] wr_addr_b;
    logic [7:0]  wr_data_b;
    logic [1:0]  err_code_b;

    int checks = 0;
    int errors = 0;

    logic [7:0]  frame_q[$];
    logic [19:0] wq_a[$], wq_b[$];
    logic [19:0] exp_wa[$], exp_wb[$];
    int          exp_send, exp_len;
    bit          exp_hdr_ok, exp_done;
    logic [1:0]  exp_err;

    program_loader #(.ADDR_W(12), .DATA_W(8), .BASE_ADDR(BASE_A), .TIMEOUT_CYC(TMO)) dut_a (
        .clock(clock), .reset_n(reset_n), .start(start), .in_valid(in_valid),
        .in_byte(in_byte), .in_ready(in_ready_a), .wr_en(wr_en_a), .wr_addr(wr_addr_a),
        .wr_data(wr_data_a), .cpu_hold(cpu_hold_a), .busy(busy_a), .done(done_a),
        .error(error_a), .err_code(err_code_a));

    program_loader #(.ADDR_W(12), .DATA_W(8), .BASE_ADDR(BASE_B), .TIMEOUT_CYC(TMO)) dut_b (
        .clock(clock), .reset_n(reset_n), .start(start), .in_valid(in_valid),
        .in_byte(in_byte), .in_ready(in_ready_b), .wr_en(wr_en_b), .wr_addr(wr_addr_b),
        .wr_data(wr_data_b), .cpu_hold(cpu_hold_b), .busy(busy_b), .done(done_b),
        .error(error_b), .err_code(err_code_b));

    always #5 clock = ~clock;

    // Capture every memory write seen by each loader
    always @(negedge clock) begin
        if (wr_en_a) wq_a.push_back({wr_addr_a, wr_data_a});
        if (wr_en_b) wq_b.push_back({wr_addr_b, wr_data_b});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: what a frame of frame_q should do when only the first
    // n_stop bytes are offered before the source goes quiet.
    task automatic model_frame(input int n_stop);
        int full_n, n_data;
        logic [7:0] sum;
        logic [11:0] l12;
        exp_wa.delete();
        exp_wb.delete();
        exp_hdr_ok = (frame_q[0][7:4] == 4'h0);
        if (exp_hdr_ok) begin
            l12     = {frame_q[0][3:0], frame_q[1]};
            exp_len = int'(l12);
            full_n  = 2 + exp_len + CSUM_BYTES;
        end else begin
            exp_len = 0;
            full_n  = 1;
        end
        exp_send = (n_stop < full_n) ? n_stop : full_n;
        n_data   = exp_send - 2;
        if (n_data < 0) n_data = 0;
        if (n_data > exp_len) n_data = exp_len;
        sum = 8'h00;
        for (int i = 0; i < exp_len; i++) sum = sum + frame_q[2 + i];
        for (int i = 0; i < n_data; i++) begin
            exp_wa.push_back({BASE_A + 12'(i), frame_q[2 + i]});
            exp_wb.push_back({BASE_B + 12'(i), frame_q[2 + i]});
        end
        exp_done = 1'b0;
        if (exp_send < full_n)                                    exp_err = 2'b01;
        else if (!exp_hdr_ok)                                     exp_err = 2'b11;
        else if (CSUM_BYTES == 1 && frame_q[2 + exp_len] != sum)  exp_err = 2'b10;
        else begin
            exp_err  = 2'b00;
            exp_done = 1'b1;
        end
    endtask

    // Offer one byte for one cycle; it must be accepted, and a data byte must
    // appear on the write port in the following cycle.
    task automatic send_byte(input logic [7:0] b, input bit is_data, input bit with_start);
        in_valid = 1'b1;
        in_byte  = b;
        start    = with_start;
        chk("in_ready_a", in_ready_a, 1'b1);
        chk("in_ready_b", in_ready_b, 1'b1);
        @(negedge clock);
        in_valid = 1'b0;
        start    = 1'b0;
        chk("wr_en_next", wr_en_a, is_data);
    endtask

    task automatic pulse_start();
        wq_a.delete();
        wq_b.delete();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("start_busy", busy_a, 1'b1);
        chk("start_hold", cpu_hold_a, 1'b1);
        chk("start_done", done_a, 1'b0);
        chk("start_err", {error_a, err_code_a}, 3'b000);
    endtask

    task automatic run_frame(input int n_stop, input bit start_mid);
        bit is_data;
        model_frame(n_stop);
        pulse_start();
        for (int p = 0; p < exp_send; p++) begin
            repeat ($urandom_range(0, 3)) @(negedge clock);
            is_data = exp_hdr_ok && (p >= 2) && (p < 2 + exp_len);
            send_byte(frame_q[p], is_data, start_mid && (p == 3));
        end
        if (exp_err == 2'b01) begin
            for (int k = 1; k <= TMO; k++) begin
                @(negedge clock);
                chk("tmo_edge", error_a, (k == TMO));
            end
        end else begin
            repeat (2) @(negedge clock);
        end
        chk("done_a", done_a, exp_done);
        chk("error_a", error_a, !exp_done);
        chk("err_code_a", err_code_a, exp_err);
        chk("cpu_hold_a", cpu_hold_a, !exp_done);
        chk("busy_a", busy_a, 1'b0);
        chk("in_ready_idle", in_ready_a, 1'b0);
        chk("status_b", {done_b, error_b, err_code_b, cpu_hold_b},
            {exp_done, !exp_done, exp_err, !exp_done});
        chk("wr_count_a", wq_a.size(), exp_wa.size());
        chk("wr_count_b", wq_b.size(), exp_wb.size());
        for (int i = 0; i < exp_wa.size() && i < wq_a.size(); i++) chk("wr_a", wq_a[i], exp_wa[i]);
        for (int i = 0; i < exp_wb.size() && i < wq_b.size(); i++) chk("wr_b", wq_b[i], exp_wb[i]);
        $display("frame len=%0d sent=%0d err_code=%0b done=%0b writes=%0d",
                 exp_len, exp_send, err_code_a, done_a, wq_a.size());
    endtask

    task automatic set_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                             input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5);
        frame_q.delete();
        frame_q.push_back(b0); frame_q.push_back(b1); frame_q.push_back(b2);
        frame_q.push_back(b3); frame_q.push_back(b4); frame_q.push_back(b5);
    endtask

    task automatic build_random(output int n_stop);
        int len, kind, full_n;
        logic [11:0] l12;
        logic [7:0] s, b;
        frame_q.delete();
        len  = $urandom_range(0, 20);
        l12  = 12'(len);
        kind = $urandom_range(0, 9);
        if (kind == 0) frame_q.push_back({4'($urandom_range(1, 15)), 4'($urandom_range(0, 15))});
        else           frame_q.push_back({4'h0, l12[11:8]});
        frame_q.push_back(l12[7:0]);
        s = 8'h00;
        for (int i = 0; i < len; i++) begin
            b = 8'($urandom);
            frame_q.push_back(b);
            s = s + b;
        end
        if (kind == 1) s = s ^ 8'($urandom_range(1, 255));
        frame_q.push_back(s);
        full_n = 2 + len + CSUM_BYTES;
        n_stop = (kind == 2) ? $urandom_range(0, full_n - 1) : 1000;
    endtask

    initial begin
        int n_stop;
        #1;
        chk("rst_in_ready", in_ready_a, 1'b0);
        chk("rst_outs", {wr_en_a, cpu_hold_a, busy_a, done_a, error_a, err_code_a}, 7'd0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        // Good frame, then the same frame with a wrong checksum byte
        set_frame(8'h00, 8'h03, 8'hA1, 8'hB2, 8'hC3, 8'h16);
        run_frame(1000, 1'b0);
        set_frame(8'h00, 8'h03, 8'hA1, 8'hB2, 8'hC3, 8'h17);
        run_frame(1000, 1'b0);
        // Bad header
        set_frame(8'h10, 8'h03, 8'hA1, 8'hB2, 8'hC3, 8'h16);
        run_frame(1000, 1'b0);
        // Source stalls after two data bytes
        set_frame(8'h00, 8'h03, 8'hA1, 8'hB2, 8'hC3, 8'h16);
        run_frame(4, 1'b0);
        // Address wrap on the high-base loader, start pulsed mid-frame
        set_frame(8'h00, 8'h03, 8'h01, 8'h02, 8'h03, 8'h06);
        run_frame(1000, 1'b1);
        // Zero-length frame
        set_frame(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        run_frame(1000, 1'b0);

        for (int f = 0; f < 40; f++) begin
            build_random(n_stop);
            run_frame(n_stop, ($urandom_range(0, 3) == 0));
        end

        // Asynchronous reset in the middle of a frame, right after a write
        set_frame(8'h00, 8'h05, 8'h11, 8'h22, 8'h33, 8'h44);
        pulse_start();
        send_byte(8'h00, 1'b0, 1'b0);
        send_byte(8'h05, 1'b0, 1'b0);
        send_byte(8'h11, 1'b1, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_in_ready", in_ready_a, 1'b0);
        chk("arst_wr", {wr_en_a, wr_addr_a, wr_data_a}, 21'd0);
        chk("arst_status", {cpu_hold_a, busy_a, done_a, error_a, err_code_a}, 6'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        chk("post_rst_ready", in_ready_a, 1'b0);
        chk("post_rst_busy", busy_a, 1'b0);
        $display("async reset mid-frame: in_ready=%0b busy=%0b", in_ready_a, busy_a);

        // The loader still works normally after the abandoned frame
        set_frame(8'h00, 8'h03, 8'hA1, 8'hB2, 8'hC3, 8'h16);
        run_frame(1000, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
